// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter
interface alu_share_arbiter_if #(
    parameter int size    = 32,
    parameter int NUM_REQ = 2
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*size-1:0] req_a;
    logic [NUM_REQ*size-1:0] req_b;
    logic [NUM_REQ*3-1:0]    req_sel;
    logic [size-1:0]         alu_a;
    logic [size-1:0]         alu_b;
    logic [2:0]              alu_sel;
    logic [size-1:0]         alu_s;
    logic [3:0]              alu_flags;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [size-1:0]         rsp_s;
    logic [3:0]              rsp_flags;
    modport slave (
        input  req_valid, req_a, req_b, req_sel, alu_s, alu_flags, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_s, rsp_flags
    );
    modport master (
        output req_valid, req_a, req_b, req_sel, alu_s, alu_flags, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_s, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU with a registered response stage
module alu_share_arbiter #(
    parameter int size    = 32,
    parameter int NUM_REQ = 2
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [size-1:0] rsp_s_q, rsp_s_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic            hit, accept, xfer;
    logic [ID_W-1:0] gidx;
    // Pick the first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        hit  = 1'b0;
        gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!hit && bus.req_valid[ID_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
                hit  = 1'b1;
                gidx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end
    assign accept        = !rsp_valid_q || bus.rsp_ready;
    assign xfer          = hit && accept && !reset;
    assign bus.req_ready = xfer ? (NUM_REQ'(1) << gidx) : '0;
    assign bus.alu_a     = hit ? bus.req_a[gidx*size +: size] : '0;
    assign bus.alu_b     = hit ? bus.req_b[gidx*size +: size] : '0;
    assign bus.alu_sel   = hit ? bus.req_sel[gidx*3 +: 3] : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_s     = rsp_s_q;
    assign bus.rsp_flags = rsp_flags_q;
    // Capture the ALU result on transfer, drop valid on a drain, otherwise hold
    always_comb begin
        rsp_valid_d = xfer ? 1'b1 : (bus.rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_id_d    = xfer ? gidx : rsp_id_q;
        rsp_s_d     = xfer ? bus.alu_s : rsp_s_q;
        rsp_flags_d = xfer ? bus.alu_flags : rsp_flags_q;
        rr_ptr_d    = xfer ? ID_W'((int'(gidx) + 1) % NUM_REQ) : rr_ptr_q;
    end
    // Response and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
            rsp_flags_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_flags_q <= rsp_flags_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random checks of the shared-ALU arbiter against a reference model
module tb_alu_share_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] vld = '0;
    logic rdy = 1'b0;
    logic [31:0] ra [N];
    logic [31:0] rb [N];
    logic [2:0]  rs [N];
    int total = 0;
    int bad = 0;
    logic        m_valid = 1'b0;
    int          m_id = 0;
    logic [31:0] m_s = '0;
    logic [3:0]  m_flags = '0;
    int          m_ptr = 0;

    alu_share_arbiter_if #(.size(32), .NUM_REQ(N)) bus ();
    alu_share_arbiter #(.size(32), .NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    assign bus.req_valid = vld;
    assign bus.rsp_ready = rdy;
    assign bus.alu_s     = bus.alu_a + bus.alu_b;
    assign bus.alu_flags = {1'b0, bus.alu_sel};
    for (genvar i = 0; i < N; i++) begin : g_pack
        assign bus.req_a[i*32 +: 32] = ra[i];
        assign bus.req_b[i*32 +: 32] = rb[i];
        assign bus.req_sel[i*3 +: 3] = rs[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic cyc();
        int g;
        logic acc;
        acc = !m_valid || rdy;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        #1;
        chk("req_ready", 64'(bus.req_ready), (g >= 0 && acc && !reset) ? 64'(1) << g : 64'(0));
        chk("alu_a", 64'(bus.alu_a), g >= 0 ? 64'(ra[g]) : 64'(0));
        chk("alu_b", 64'(bus.alu_b), g >= 0 ? 64'(rb[g]) : 64'(0));
        chk("alu_sel", 64'(bus.alu_sel), g >= 0 ? 64'(rs[g]) : 64'(0));
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_id = 0; m_s = '0; m_flags = '0; m_ptr = 0;
        end else if (g >= 0 && acc) begin
            m_valid = 1'b1; m_id = g; m_s = ra[g] + rb[g]; m_flags = {1'b0, rs[g]}; m_ptr = (g + 1) % N;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        chk("rsp_s", 64'(bus.rsp_s), 64'(m_s));
        chk("rsp_flags", 64'(bus.rsp_flags), 64'(m_flags));
        chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ra[i] = 32'(100 * (i + 1)); rb[i] = 32'(i + 1); rs[i] = 3'(i + 4);
        end
        cyc(); cyc();
        reset = 1'b0;
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        // Single request
        ra[0] = 32'd5; rb[0] = 32'd3; rs[0] = 3'b010; vld = 4'b0001; rdy = 1'b1;
        cyc();
        vld = '0;
        chk("single_s", 64'(bus.rsp_s), 64'd8);
        chk("single_flags", 64'(bus.rsp_flags), 64'b0010);
        chk("single_id", 64'(bus.rsp_id), 64'd0);
        // Reset while a response is held
        rdy = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_mid_s", 64'(bus.rsp_s), 64'd0);
        // Two requesters held: alternate 0,1,0,1
        vld = 4'b0011; rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("alt_id", 64'(bus.rsp_id), 64'(k % 2));
        end
        // Backpressure for 3 cycles, then release
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_id", 64'(bus.rsp_id), 64'd1);
        end
        rdy = 1'b1;
        cyc();
        chk("release_id", 64'(bus.rsp_id), 64'd0);
        // Wrap: only req3, then only req1, starting from rr_ptr=0
        vld = '0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        vld = 4'b1000;
        cyc();
        chk("wrap_id3", 64'(bus.rsp_id), 64'd3);
        chk("wrap_ptr0", 64'(dut.rr_ptr_q), 64'd0);
        vld = 4'b0010;
        cyc();
        chk("wrap_id1", 64'(bus.rsp_id), 64'd1);
        chk("wrap_ptr2", 64'(dut.rr_ptr_q), 64'd2);
        // Idle for 5 cycles
        vld = '0;
        for (int k = 0; k < 5; k++) cyc();
        chk("idle_valid", 64'(bus.rsp_valid), 64'd0);
        chk("idle_ptr", 64'(dut.rr_ptr_q), 64'd2);
        // Random traffic
        for (int t = 0; t < 400; t++) begin
            vld = 4'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                ra[i] = $urandom; rb[i] = $urandom; rs[i] = 3'($urandom);
            end
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
